// File: rtl/udma_apb_master_if.sv
// Request/response handshake plus APB3 bus seen by udma_apb_master.
// The master modport is the initiator's view; slave is the environment (requester + APB target).
interface udma_apb_master_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [APB_ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]               req_wdata_i;
  logic                      req_write_i;

  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [31:0]               rsp_rdata_o;
  logic                      rsp_err_o;

  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/udma_apb_master.sv
// Single-outstanding request/response to APB3 initiator with fully registered APB outputs.
// Define UDMA_APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module udma_apb_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk_i,
  input logic              rst_i,
  udma_apb_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("udma_apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

`ifdef UDMA_APB_MASTER_TIMEOUT_EN
  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef UDMA_APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          paddr_d   = bus.req_addr_i;
          pwdata_d  = bus.req_wdata_i;
          pwrite_d  = bus.req_write_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef UDMA_APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ACCESS: begin
        // PREADY wins over a timeout landing in the same cycle.
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
          rsp_err_d   = bus.PSLVERR;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef UDMA_APB_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef UDMA_APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;

endmodule
